// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_subtractor: D = A - B - Bin, DIGIT bits per clock, LSB first.    |
// | Optional V/Z flags when SERIAL_SUB_FLAGS_EN is defined.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module serial_subtractor #(
  parameter int BITS  = 32,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            Bin,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] D,
`ifdef SERIAL_SUB_FLAGS_EN
  output logic            Bout,
  output logic            V,
  output logic            Z
`else
  output logic            Bout
`endif
);

  localparam int N     = BITS / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int RES_W = BITS - DIGIT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [BITS-1:0]    r_a;
  logic [BITS-1:0]    r_b;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  // Holds the N-1 digits already produced; the last digit joins it on the final edge.
  logic [RES_W-1:0]   r_res;
  logic [BITS-1:0]    r_d;
  logic               r_bout;

  logic [DIGIT:0]     w_c;
  logic [DIGIT-1:0]   w_s;
  logic               w_borrow_out;
  logic [BITS-1:0]    w_diff;
  logic               w_last;
  logic               w_accept;
  logic               w_finish;

  // A - B - borrow as A + ~B + ~borrow; borrow is the inverted carry.
  assign w_c[0] = ~r_borrow;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    logic w_nb;
    assign w_nb        = ~r_b[gi];
    assign w_s[gi]     = r_a[gi] ^ w_nb ^ w_c[gi];
    assign w_c[gi + 1] = (r_a[gi] & w_nb) | (r_a[gi] & w_c[gi]) | (w_nb & w_c[gi]);
  end

  assign w_borrow_out = ~w_c[DIGIT];
  assign w_diff       = {w_s, r_res};
  assign w_last       = (r_cnt == CNT_W'(N - 1));
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_finish     = (r_state == S_RUN) && w_last;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
    end else if (w_accept) begin
      r_a      <= A;
      r_b      <= B;
      r_borrow <= Bin;
      r_cnt    <= '0;
      r_res    <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_borrow <= w_borrow_out;
      r_cnt    <= r_cnt + CNT_W'(1);
      r_res    <= {w_s, r_res[RES_W-1:DIGIT]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_finish) begin
      r_d    <= w_diff;
      r_bout <= w_borrow_out;
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic r_v;
  logic r_z;

  // On the final digit the low bit positions of r_a/r_b hold the operand MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 1'b0;
      r_z <= 1'b0;
    end else if (w_finish) begin
      r_v <= (r_a[DIGIT-1] != r_b[DIGIT-1]) && (w_s[DIGIT-1] != r_a[DIGIT-1]);
      r_z <= (w_diff == '0);
    end
  end

  assign V = r_v;
  assign Z = r_z;
`endif

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign D    = r_d;
  assign Bout = r_bout;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle 32-bit subtractor computing D = A − B − Bin, DIGIT bits per clock, LSB digit first, with a start/busy/done handshake. It is the inverse-direction companion of the combinational ripple-carry adder in the CS220 datapath. It trades latency for area: one DIGIT-wide borrow chain is reused across bits_/DIGIT cycles instead of bits_ cascaded slices. It sits between the operand registers and the result register of the lab ALU.

## Interface
- bits_, 32, operand and result width.
- DIGIT, 1, bits processed per cycle. Must divide bits_; legal values are 1, 2, 4, 8.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- A  input  bits_  minuend, latched on the accepted start.
- B  input  bits_  subtrahend, latched on the accepted start.
- Bin  input  1  borrow-in, latched on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when D, Bout and the flags become valid.
- D  output  bits_  difference register, held until the next completion.
- Bout  output  1  borrow-out of the MSB (1 means A < B + Bin, unsigned).
- V  output  1  signed overflow (only with SERIAL_SUB_FLAGS_EN).
- Z  output  1  D == 0 (only with SERIAL_SUB_FLAGS_EN).

## Operation
- States:
  - IDLE → RUN on start=1. The block latches A, B, Bin into working registers, clears the digit counter, and sets the internal borrow to Bin.
  - RUN → RUN while the counter is below N−1, where N = bits_/DIGIT.
  - RUN → DONE after the digit with counter = N−1 is processed.
  - DONE → IDLE unconditionally after one cycle.
- Each RUN cycle:
  - Compute the current DIGIT slice of A − B − borrow as A + ~B + ~borrow, DIGIT full-adder slices, with borrow = ~carry.
  - Write the slice into a result shift register and shift the A and B working registers right by DIGIT.
  - Update the borrow from the last slice.
- On the RUN→DONE edge: load D from the result register and Bout from the final borrow. V and Z load on the same edge.
- start while busy=1 or done=1 is ignored, with no queuing. Operands may change freely after acceptance.
- D, Bout, V and Z hold their values through IDLE and RUN until the next DONE. They are never partially updated.
- Arithmetic is modulo 2^bits_. Bin=1 subtracts one extra.
- Reset, asserted at any time including mid-RUN:
  - Go to IDLE immediately.
  - busy=0, done=0, D=0, Bout=0, V=0, Z=0. Working registers and counter are cleared.
  - The aborted operation produces no done.

## Timing
- Accepted start at edge k gives busy=1 after edge k through edge k+N.
- done=1 for exactly the cycle after edge k+N. busy=0 in that cycle.
- Latency from accepting edge to done is N+1 cycles: 33 for the defaults, 9 for DIGIT=4.
- Minimum start-to-start spacing is N+2 cycles: start is next accepted at the edge after the done cycle.
- Critical path is one DIGIT-wide ripple chain plus counter compare. It is independent of bits_.

## Configuration
- SERIAL_SUB_FLAGS_EN defined:
  - Ports V and Z exist.
  - V = (A[msb] ≠ B[msb]) && (D[msb] ≠ A[msb]), computed from the latched operand MSBs.
  - Z = (D == 0).
  - Both are registered on the DONE edge alongside D and reset to 0.
- SERIAL_SUB_FLAGS_EN undefined: V, Z and their logic are absent. The other behaviour is unchanged.

## Test plan
- A=10, B=5, Bin=0, start at edge 0 (defaults) → busy for 32 cycles, done pulse in cycle 33, D=5, Bout=0, Z=0.
- A=0, B=1, Bin=0 → D=0xFFFFFFFF, Bout=1. Then A=7, B=6, Bin=1 → D=0, Bout=0, Z=1.
- With flags: A=0x80000000, B=1 → D=0x7FFFFFFF, V=1. Then A=0x7FFFFFFF, B=0xFFFFFFFF → D=0x80000000, V=1, Bout=1.
- Pulse start again at cycles 5 and 33 (the done cycle) of a run → both ignored, exactly one done, D unchanged by the new A/B. Start at cycle 34 → accepted.
- Assert rst at cycle 10 of a run over a previous result D=5 → done never pulses, D=0, busy=0 asynchronously. Next start runs a full 32 cycles correctly.
- DIGIT=4, A=0x12345678, B=0x11111111 → done 9 cycles after the accepting edge, D=0x01234567, Bout=0.
